// File: rtl/alu_div_pkg.sv
// Shared constants for the execute-stage divider: result width, ALU flag layout, FSM states.
package alu_div_pkg;
  localparam int RW = 16;

  localparam int ALU_FLAG_Z   = 0;
  localparam int ALU_FLAG_C   = 1;
  localparam int ALU_FLAG_N   = 2;
  localparam int ALU_FLAG_O   = 3;
  localparam int ALU_FLAG_P   = 4;
  localparam int ALU_FLAG_CNT = 5;

  localparam int DIV_STATE_W = 2;
  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic         q
);
  logic [W+1:0] diff;

  // One extra bit above the shifted remainder carries the borrow of the trial subtract.
  assign diff    = {rem, bit_in} - {2'b00, dvs};
  assign q       = ~diff[W+1];
  assign rem_nxt = q ? diff[W:0] : {rem[W-1:0], bit_in};
endmodule

// File: rtl/alu_div.sv
// Iterative signed/unsigned restoring divider; one quotient bit per cycle, stalls via o_busy.
module alu_div
  import alu_div_pkg::*;
#(
  parameter int W = RW
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic                    i_signed,
  input  logic                    i_rem,
  input  logic [W-1:0]            i_l,
  input  logic [W-1:0]            i_r,
  input  logic                    i_flush,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [W-1:0]            o_out,
  output logic [ALU_FLAG_CNT-1:0] o_flags
);
  localparam int CW = $clog2(W) + 1;

  div_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd;     // dividend in, quotient bits shift in from the LSB
  logic [W-1:0]  dvs;
  logic [W:0]    prem;
  logic          q_neg, r_neg, sel_rem, dz, ov;

  logic [W:0]    rem_nxt;
  logic          q_bit;
  logic          acc;
  logic [W-1:0]  l_abs, r_abs, q_fix, r_fix, res;
  logic [ALU_FLAG_CNT-1:0] fl;

  div_step #(.W(W)) u_step (
    .rem     (prem),
    .bit_in  (dvd[W-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q       (q_bit)
  );

  assign acc   = (state == DIV_IDLE) && i_req && !i_flush;
  assign l_abs = (i_signed && i_l[W-1]) ? -i_l : i_l;
  assign r_abs = (i_signed && i_r[W-1]) ? -i_r : i_r;

  // Div-by-zero forces all ones regardless of sign; the remainder naturally equals the dividend.
  assign q_fix = dz ? '1 : (q_neg ? -dvd : dvd);
  assign r_fix = r_neg ? -prem[W-1:0] : prem[W-1:0];
  assign res   = sel_rem ? r_fix : q_fix;

  always_comb begin
    fl             = '0;
    fl[ALU_FLAG_Z] = (res == '0);
    fl[ALU_FLAG_C] = dz;
    fl[ALU_FLAG_N] = res[W-1];
    fl[ALU_FLAG_O] = ov;
    fl[ALU_FLAG_P] = ^res;
  end

  always_comb begin
    nxt = state;
    case (state)
      DIV_IDLE: if (i_req) nxt = DIV_CALC;
      DIV_CALC: if (cnt == CW'(W-1)) nxt = DIV_DONE;
      DIV_DONE: nxt = DIV_IDLE;
      default:  nxt = DIV_IDLE;
    endcase
    if (i_flush) nxt = DIV_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= DIV_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      sel_rem <= 1'b0;
      dz      <= 1'b0;
      ov      <= 1'b0;
      o_valid <= 1'b0;
      o_out   <= '0;
      o_flags <= '0;
    end else begin
      o_valid <= 1'b0;
      if (acc) begin
        dvd     <= l_abs;
        dvs     <= r_abs;
        prem    <= '0;
        cnt     <= '0;
        sel_rem <= i_rem;
        q_neg   <= i_signed & (i_l[W-1] ^ i_r[W-1]);
        r_neg   <= i_signed & i_l[W-1];
        dz      <= (i_r == '0);
        ov      <= i_signed && (i_l == {1'b1, {(W-1){1'b0}}}) && (&i_r);
      end else if (!i_flush && state == DIV_CALC) begin
        prem <= rem_nxt;
        dvd  <= {dvd[W-2:0], q_bit};
        cnt  <= cnt + 1'b1;
      end else if (!i_flush && state == DIV_DONE) begin
        o_out   <= res;
        o_flags <= fl;
        o_valid <= 1'b1;
      end
    end
  end

  assign o_busy = (state != DIV_IDLE);
endmodule
